// File: rtl/dreg_op_sequencer.sv
// Sequences one Dd <= Dd op Ds register-file operation through a shared
// 16-bit ALU, chaining the low-half carry into the high half for long ops.
module dreg_op_sequencer #(
   parameter int unsigned SEL_W = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [1:0]       cmd_size,
   input  logic [SEL_W-1:0] cmd_src,
   input  logic [SEL_W-1:0] cmd_dst,
   output logic [SEL_W-1:0] dreg_sel_a,
   output logic [SEL_W-1:0] dreg_sel_b,
   input  logic [31:0]      rd_a,
   input  logic [31:0]      rd_b,
   output logic             dreg_set,
   output logic [31:0]      dreg_data,
   output logic [2:0]       alu_op,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic             alu_cin,
   input  logic [15:0]      alu_out,
   input  logic             alu_cout,
   output logic             done,
   output logic [3:0]       flags
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned HALF_W = 16;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned SZ_W   = 2;

   localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
   localparam logic [OP_W-1:0] OP_MOVE = 3'd5;

   localparam logic [SZ_W-1:0] SZ_BYTE = 2'd0;
   localparam logic [SZ_W-1:0] SZ_WORD = 2'd1;
   localparam logic [SZ_W-1:0] SZ_LONG = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_LO    = 3'd2,
      ST_HI    = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [SZ_W-1:0]     size_q, size_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [HALF_W-1:0]   res_lo_q, res_lo_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic [SEL_W-1:0]    dreg_sel_a_q, dreg_sel_a_d;
   logic [SEL_W-1:0]    dreg_sel_b_q, dreg_sel_b_d;
   logic                dreg_set_q, dreg_set_d;
   logic [DATA_W-1:0]   dreg_data_q, dreg_data_d;
   logic [OP_W-1:0]     alu_op_q, alu_op_d;
   logic [HALF_W-1:0]   alu_a_q, alu_a_d;
   logic [HALF_W-1:0]   alu_b_q, alu_b_d;
   logic                alu_cin_q, alu_cin_d;
   logic                done_q, done_d;
   logic [3:0]          flags_q, flags_d;
   logic                lo_carry;

   // {N,Z,V,C} on the operand width; a is Dd, b is Ds
   function automatic logic [3:0] calc_flags(input logic [OP_W-1:0]   op,
                                              input logic [SZ_W-1:0]   size,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] r,
                                              input logic              c);
      logic sa, sb, sr, z, v, cf;
      sa = a[31];
      sb = b[31];
      sr = r[31];
      z  = (r == 32'h0);
      v  = 1'b0;
      cf = 1'b0;
      case (size)
         SZ_BYTE: begin
            sa = a[7];
            sb = b[7];
            sr = r[7];
            z  = (r[7:0] == 8'h0);
         end
         SZ_WORD: begin
            sa = a[15];
            sb = b[15];
            sr = r[15];
            z  = (r[15:0] == 16'h0);
         end
         default: ;
      endcase
      if (op == OP_ADD) begin
         v  = (sa == sb) && (sr != sa);
         cf = c;
      end else if (op == OP_SUB) begin
         v  = (sa != sb) && (sr != sa);
         cf = c;
      end
      return {sr, z, v, cf};
   endfunction

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         size_q       <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         res_lo_q     <= '0;
         cmd_ready_q  <= 1'b1;
         dreg_sel_a_q <= '0;
         dreg_sel_b_q <= '0;
         dreg_set_q   <= 1'b0;
         dreg_data_q  <= '0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cin_q    <= 1'b0;
         done_q       <= 1'b0;
         flags_q      <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         size_q       <= size_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         res_lo_q     <= res_lo_d;
         cmd_ready_q  <= cmd_ready_d;
         dreg_sel_a_q <= dreg_sel_a_d;
         dreg_sel_b_q <= dreg_sel_b_d;
         dreg_set_q   <= dreg_set_d;
         dreg_data_q  <= dreg_data_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         done_q       <= done_d;
         flags_q      <= flags_d;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cmd_valid) state_d = ST_READ;
         ST_READ:  state_d = ST_LO;
         ST_LO:    state_d = (size_q == SZ_LONG) ? ST_HI : ST_WRITE;
         ST_HI:    state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and next values of the registered outputs
   always_comb begin
      op_d         = op_q;
      size_d       = size_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      res_lo_d     = res_lo_q;
      cmd_ready_d  = (state_d == ST_IDLE);
      dreg_sel_a_d = dreg_sel_a_q;
      dreg_sel_b_d = dreg_sel_b_q;
      dreg_set_d   = 1'b0;
      dreg_data_d  = dreg_data_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cin_d    = alu_cin_q;
      done_d       = 1'b0;
      flags_d      = flags_q;
      lo_carry     = (size_q == SZ_BYTE) ? alu_out[8] : alu_cout;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d         = (cmd_op > OP_MOVE) ? OP_MOVE : cmd_op;
               size_d       = (cmd_size == 2'd3) ? SZ_LONG : cmd_size;
               dreg_sel_a_d = cmd_src;
               dreg_sel_b_d = cmd_dst;
            end
         end
         ST_READ: begin
            opa_d     = rd_b;
            opb_d     = rd_a;
            alu_op_d  = op_q;
            alu_cin_d = 1'b0;
            if (size_q == SZ_BYTE) begin
               alu_a_d = {8'h00, rd_b[7:0]};
               alu_b_d = {8'h00, rd_a[7:0]};
            end else begin
               alu_a_d = rd_b[15:0];
               alu_b_d = rd_a[15:0];
            end
         end
         ST_LO: begin
            res_lo_d = alu_out;
            if (size_q == SZ_LONG) begin
               alu_a_d   = opa_q[31:16];
               alu_b_d   = opb_q[31:16];
               alu_cin_d = lo_carry;
            end else begin
               dreg_set_d  = 1'b1;
               done_d      = 1'b1;
               dreg_data_d = (size_q == SZ_BYTE) ? {opa_q[31:8], alu_out[7:0]}
                                                 : {opa_q[31:16], alu_out};
               flags_d     = calc_flags(op_q, size_q, opa_q, opb_q,
                                        {16'h0000, alu_out}, lo_carry);
            end
         end
         ST_HI: begin
            dreg_set_d  = 1'b1;
            done_d      = 1'b1;
            dreg_data_d = {alu_out, res_lo_q};
            flags_d     = calc_flags(op_q, size_q, opa_q, opb_q,
                                     {alu_out, res_lo_q}, alu_cout);
         end
         default: ;
      endcase
   end

   assign cmd_ready  = cmd_ready_q;
   assign dreg_sel_a = dreg_sel_a_q;
   assign dreg_sel_b = dreg_sel_b_q;
   assign dreg_set   = dreg_set_q;
   assign dreg_data  = dreg_data_q;
   assign alu_op     = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign done       = done_q;
   assign flags      = flags_q;

endmodule

// File: tb/tb_dreg_op_sequencer.sv
// Bench for dreg_op_sequencer: behavioural register file and ALU around the
// DUT, expected writes queued at issue time and compared at each done pulse.
module tb_dreg_op_sequencer;

   localparam int unsigned SEL_W = 3;

   logic             CLK = 1'b0;
   logic             RESET = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [1:0]       cmd_size = '0;
   logic [SEL_W-1:0] cmd_src = '0;
   logic [SEL_W-1:0] cmd_dst = '0;
   logic [SEL_W-1:0] dreg_sel_a, dreg_sel_b;
   logic [31:0]      rd_a, rd_b;
   logic             dreg_set;
   logic [31:0]      dreg_data;
   logic [2:0]       alu_op;
   logic [15:0]      alu_a, alu_b;
   logic             alu_cin;
   logic [15:0]      alu_out;
   logic             alu_cout;
   logic             done;
   logic [3:0]       flags;

   typedef struct {
      logic [2:0]  dst;
      logic [31:0] data;
      logic [3:0]  flags;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] rf [8];
   logic [31:0] mdl[8];
   logic        ld_en = 1'b0;
   logic [2:0]  ld_sel = '0;
   logic [31:0] ld_val = '0;
   logic [16:0] alu_w;
   int          total = 0;
   int          bad = 0;

   always #5 CLK = ~CLK;

   dreg_op_sequencer #(.SEL_W(SEL_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_size(cmd_size), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
      .dreg_sel_a(dreg_sel_a), .dreg_sel_b(dreg_sel_b),
      .rd_a(rd_a), .rd_b(rd_b),
      .dreg_set(dreg_set), .dreg_data(dreg_data),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .done(done), .flags(flags)
   );

   // register file: bench preload port has priority over the DUT write
   assign rd_a = rf[dreg_sel_a];
   assign rd_b = rf[dreg_sel_b];
   always @(posedge CLK) begin
      if (ld_en) rf[ld_sel] <= ld_val;
      else if (dreg_set) rf[dreg_sel_b] <= dreg_data;
   end

   // 16-bit ALU with carry (ADD) / borrow (SUB) out of bit 15
   always_comb begin
      alu_w = '0;
      case (alu_op)
         3'd0:    alu_w = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
         3'd1:    alu_w = {1'b0, alu_a} - {1'b0, alu_b} - 17'(alu_cin);
         3'd2:    alu_w = {1'b0, alu_a & alu_b};
         3'd3:    alu_w = {1'b0, alu_a | alu_b};
         3'd4:    alu_w = {1'b0, alu_a ^ alu_b};
         default: alu_w = {1'b0, alu_b};
      endcase
   end
   assign alu_out  = alu_w[15:0];
   assign alu_cout = alu_w[16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [2:0] r, input logic [31:0] v);
      ld_en  = 1'b1;
      ld_sel = r;
      ld_val = v;
      @(negedge CLK);
      ld_en  = 1'b0;
      mdl[r] = v;
   endtask

   // full-width reference for one op; pushes the expected write and flags
   task automatic expect_op(input logic [2:0] op, input logic [1:0] size,
                            input logic [2:0] src, input logic [2:0] dst);
      logic [31:0] a, b, m, am, bm, r;
      logic [32:0] w;
      logic        n, z, v, c;
      int          s;
      exp_t        e;
      a = mdl[dst];
      b = mdl[src];
      case (size)
         2'd0:    begin s = 7;  m = 32'h0000_00FF; end
         2'd1:    begin s = 15; m = 32'h0000_FFFF; end
         default: begin s = 31; m = 32'hFFFF_FFFF; end
      endcase
      am = a & m;
      bm = b & m;
      case (op)
         3'd0:    w = {1'b0, am} + {1'b0, bm};
         3'd1:    w = {1'b0, am} - {1'b0, bm};
         3'd2:    w = {1'b0, am & bm};
         3'd3:    w = {1'b0, am | bm};
         3'd4:    w = {1'b0, am ^ bm};
         default: w = {1'b0, bm};
      endcase
      r = w[31:0] & m;
      c = (op == 3'd0 || op == 3'd1) ? w[s+1] : 1'b0;
      n = r[s];
      z = (r == 32'h0);
      if (op == 3'd0)      v = (a[s] == b[s]) && (r[s] != a[s]);
      else if (op == 3'd1) v = (a[s] != b[s]) && (r[s] != a[s]);
      else                 v = 1'b0;
      e.dst   = dst;
      e.data  = (a & ~m) | r;
      e.flags = {n, z, v, c};
      mdl[dst] = e.data;
      sbq.push_back(e);
   endtask

   // present a command, wait for acceptance; returns at the negedge after the accept edge
   task automatic send(input logic [2:0] op, input logic [1:0] size,
                       input logic [2:0] src, input logic [2:0] dst, input bit hold);
      int n;
      cmd_op    = op;
      cmd_size  = size;
      cmd_src   = src;
      cmd_dst   = dst;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check("accept_ready", 32'(cmd_ready), 32'd1);
      @(negedge CLK);
      if (!hold) cmd_valid = 1'b0;
   endtask

   // latency counts edges with the accept edge as 1; checks the write cycle and the one after
   task automatic wait_done(input int exp_lat);
      int   lat, early, rdy;
      exp_t e;
      lat = 1;
      early = 0;
      rdy = 0;
      while (!done && lat < 20) begin
         if (dreg_set) early++;
         if (cmd_ready) rdy++;
         @(negedge CLK);
         lat++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("early_write", 32'(early), 32'd0);
      check("ready_while_busy", 32'(rdy), 32'd0);
      check("set_with_done", 32'(dreg_set), 32'd1);
      check("ready_in_write", 32'(cmd_ready), 32'd0);
      check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("write_sel", 32'(dreg_sel_b), 32'(e.dst));
         check("write_data", dreg_data, e.data);
         @(negedge CLK);
         check("set_one_cycle", 32'(dreg_set), 32'd0);
         check("done_one_cycle", 32'(done), 32'd0);
         check("flags", 32'(flags), 32'(e.flags));
         check("rf_dst", rf[e.dst], e.data);
         check("ready_after", 32'(cmd_ready), 32'd1);
      end
   endtask

   initial begin
      int sets;
      // reset state
      repeat (2) @(negedge CLK);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_set", 32'(dreg_set), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_sel_a", 32'(dreg_sel_a), 32'd0);
      check("rst_sel_b", 32'(dreg_sel_b), 32'd0);
      check("rst_data", dreg_data, 32'd0);
      check("rst_alu", {alu_a, alu_b}, 32'd0);
      check("rst_alu_ctl", 32'({alu_op, alu_cin}), 32'd0);
      RESET = 1'b1;
      @(negedge CLK);

      // ADD.L with low-half carry into the high half
      load(3'd0, 32'h0000_FFFF);
      load(3'd1, 32'h0000_0001);
      expect_op(3'd0, 2'd2, 3'd1, 3'd0);
      send(3'd0, 2'd2, 3'd1, 3'd0, 1'b0);
      wait_done(4);

      // ADD.L wrapping to zero
      load(3'd0, 32'hFFFF_FFFF);
      expect_op(3'd0, 2'd2, 3'd1, 3'd0);
      send(3'd0, 2'd2, 3'd1, 3'd0, 1'b0);
      wait_done(4);

      // ADD.B signed overflow, upper bytes preserved
      load(3'd2, 32'h1234_567F);
      load(3'd3, 32'h0000_0001);
      expect_op(3'd0, 2'd0, 3'd3, 3'd2);
      send(3'd0, 2'd0, 3'd3, 3'd2, 1'b0);
      wait_done(3);

      // SUB.W borrow, then EOR.L (size code 3) with itself
      load(3'd4, 32'hAAAA_0000);
      load(3'd5, 32'h0000_0001);
      expect_op(3'd1, 2'd1, 3'd5, 3'd4);
      send(3'd1, 2'd1, 3'd5, 3'd4, 1'b0);
      wait_done(3);
      expect_op(3'd4, 2'd3, 3'd4, 3'd4);
      send(3'd4, 2'd3, 3'd4, 3'd4, 1'b0);
      wait_done(4);

      // back-to-back: second command (op code 6 = MOVE) held while busy
      load(3'd0, 32'h7FFF_FFFF);
      load(3'd1, 32'h0000_0001);
      expect_op(3'd0, 2'd2, 3'd1, 3'd0);
      expect_op(3'd6, 2'd1, 3'd0, 3'd1);
      send(3'd0, 2'd2, 3'd1, 3'd0, 1'b1);
      cmd_op   = 3'd6;
      cmd_size = 2'd1;
      cmd_src  = 3'd0;
      cmd_dst  = 3'd1;
      wait_done(4);
      @(negedge CLK);
      cmd_valid = 1'b0;
      wait_done(3);

      // reset during HI of an ADD.L aborts without a write
      load(3'd6, 32'h0000_FFFF);
      load(3'd7, 32'h0000_0001);
      send(3'd0, 2'd2, 3'd7, 3'd6, 1'b0);
      sets = 0;
      repeat (2) begin
         if (dreg_set) sets++;
         @(negedge CLK);
      end
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      check("abort_flags", 32'(flags), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_done", 32'(done), 32'd0);
      repeat (4) begin
         if (dreg_set) sets++;
         @(negedge CLK);
      end
      check("abort_no_write", 32'(sets), 32'd0);
      check("abort_dst_kept", rf[6], 32'h0000_FFFF);
      check("abort_idle_ready", 32'(cmd_ready), 32'd1);

      // recovery after abort: ADD.W to zero with carry
      expect_op(3'd0, 2'd1, 3'd7, 3'd6);
      send(3'd0, 2'd1, 3'd7, 3'd6, 1'b0);
      wait_done(3);
      check("sb_drained", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dreg_op_sequencer.md
Name: dreg_op_sequencer

Overview:
- Multi-cycle sequencer that executes one register-to-register operation `Dd <= Dd op Ds` on the data register file.
- Drives the file's two read selects, write select/enable and write data, and time-shares the single 16-bit ALU across low and high halves, chaining carry between them for long ops.
- Sits between instruction decode (command handshake) and the DataRegisterFile/Alu pair.
- Sizes: byte, word, long.

Parameters:
- SEL_W, 3, register select width (8 data registers).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 EOR, 5 MOVE; 6/7 treated as MOVE.
- cmd_size  in  2  0 byte, 1 word, 2 long; 3 treated as long.
- cmd_src  in  SEL_W  source register Ds.
- cmd_dst  in  SEL_W  destination register Dd.
- dreg_sel_a  out  SEL_W  read port A select (Ds).
- dreg_sel_b  out  SEL_W  read port B / write select (Dd).
- rd_a  in  32  register file port A data, combinational from dreg_sel_a.
- rd_b  in  32  register file port B data.
- dreg_set  out  1  write enable.
- dreg_data  out  32  write data.
- alu_op  out  3  same encoding as cmd_op; MOVE drives 5 (pass b).
- alu_a  out  16  ALU a operand (Dd half).
- alu_b  out  16  ALU b operand (Ds half).
- alu_cin  out  1  carry/borrow in.
- alu_out  in  16  ALU result, combinational.
- alu_cout  in  1  carry out (ADD) / borrow out (SUB) from bit 15.
- done  out  1  one-cycle pulse, coincident with the write.
- flags  out  4  {N,Z,V,C} of last completed op.

Behaviour:
Reset (RESET=0 at an edge) forces the following; a reset mid-operation aborts it with no write:
- state=IDLE, dreg_set=0, done=0, flags=0.
- dreg_sel_a=0, dreg_sel_b=0, dreg_data=0.
- alu outputs 0.

States, all outputs registered and Moore-decoded:
- IDLE: cmd_ready=1. On cmd_valid, latch op/size/src/dst, drive dreg_sel_a=src and dreg_sel_b=dst, go to READ. Commands while busy are not accepted (cmd_ready=0).
- READ: capture opA=rd_b (Dd) and opB=rd_a (Ds). Go to LO.
- LO:
  - Drive alu_a=opA[15:0], alu_b=opB[15:0], alu_cin=0, and capture res[15:0]=alu_out.
  - For byte: alu_a/alu_b carry operand bits [7:0] zero-extended.
  - Save carry: word/long take alu_cout; byte takes alu_out[8].
  - Long goes to HI; byte/word go to WRITE.
- HI: drive upper halves with alu_cin = saved carry; capture res[31:16] and carry=alu_cout. Go to WRITE.
- WRITE: dreg_set=1, done=1, dreg_sel_b=dst. Go to IDLE; cmd_ready returns high the next cycle. Write data merges result into Dd:
  - byte: {opA[31:8], res[7:0]}
  - word: {opA[31:16], res[15:0]}
  - long: res

Flags, updated only in WRITE, on width w (8/16/32) with sign bit s:
- N = res[s].
- Z = all w result bits zero; long uses both halves.
- C = final carry/borrow for ADD/SUB; 0 otherwise.
- V for ADD = (a[s]==b[s]) && (res[s]!=a[s]).
- V for SUB = (a[s]!=b[s]) && (res[s]!=a[s]), where a=Dd and b=Ds.
- V = 0 for logic ops and MOVE.

Latency and throughput:
- Long: accept edge T0, READ T1, LO T2, HI T3, WRITE/done T4.
- Byte/word: done at T3.
- Next command accepted at earliest at T5 (long) / T4.

Boundary cases:
- src==dst is legal; operands are captured in READ, before the write.
- alu_op holds the latched op from LO through WRITE.
- No write ever occurs outside WRITE.

Test Plan:
- D0=0x0000FFFF, D1=0x00000001, ADD.L src=1 dst=0 -> low-half carry chained, D0=0x00010000, flags=0000, done 4 cycles after accept, dreg_set high exactly one cycle.
- D0=0xFFFFFFFF, D1=1, ADD.L -> D0=0x00000000, flags N0 Z1 V0 C1.
- D2=0x1234567F, D3=0x00000001, ADD.B dst=2 src=3 -> D2=0x12345680, flags N1 Z0 V1 C0, done 3 cycles after accept.
- D4=0xAAAA0000, D5=0x00000001, SUB.W dst=4 src=5 -> D4=0xAAAAFFFF, flags N1 Z0 V0 C1; then EOR.L D4 with itself -> D4=0, flags Z1 only.
- Issue ADD.L and hold cmd_valid with a second command -> cmd_ready=0 until after WRITE; second command accepted the cycle after done, and both results are correct.
- Assert RESET low during HI of an ADD.L -> no dreg_set pulse, destination unchanged, state IDLE, flags=0, cmd_ready=1 the cycle after reset deasserts.
